// File: rtl/ysyx_210544_wb_commit.sv
// Writeback commit queue: buffers ALU/LSU results, retires one per cycle into the regfile
// and forwards the youngest pending write to the rs1/rs2 readers.
module ysyx_210544_wb_commit #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_alu_valid,
   output logic            o_alu_ready,
   input  logic [4:0]      i_alu_rd,
   input  logic [XLEN-1:0] i_alu_data,
   input  logic            i_lsu_valid,
   output logic            o_lsu_ready,
   input  logic [4:0]      i_lsu_rd,
   input  logic [XLEN-1:0] i_lsu_data,
   input  logic            i_wr_stall,
   output logic [4:0]      o_rd,
   output logic            o_rd_wen,
   output logic [XLEN-1:0] o_rd_data,
   input  logic [4:0]      i_rs1,
   input  logic [4:0]      i_rs2,
   output logic            o_rs1_hit,
   output logic            o_rs2_hit,
   output logic [XLEN-1:0] o_rs1_fwd,
   output logic [XLEN-1:0] o_rs2_fwd,
   output logic [31:0]     o_wb_cnt,
   output logic            o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]   wr_ptr_q, rd_ptr_q, cnt;
   logic [4:0]      rd_mem_q   [DEPTH];
   logic [XLEN-1:0] data_mem_q [DEPTH];
   logic [31:0]     wb_cnt_q;

   logic            empty, full, accept, push, pop;
   logic [4:0]      push_rd;
   logic [XLEN-1:0] push_data;
   logic [AW-1:0]   head;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign cnt   = wr_ptr_q - rd_ptr_q;
   assign head  = rd_ptr_q[AW-1:0];

   // LSU wins; ready is derived from full only, never from a same-cycle pop.
   assign accept    = (i_lsu_valid | i_alu_valid) & ~full;
   assign push_rd   = i_lsu_valid ? i_lsu_rd   : i_alu_rd;
   assign push_data = i_lsu_valid ? i_lsu_data : i_alu_data;
   assign push      = accept & (push_rd != 5'd0);
   assign pop       = ~empty & ~i_wr_stall;

   // rst gating keeps readys and empty low while reset is held.
   assign o_lsu_ready = rst & ~full;
   assign o_alu_ready = rst & ~full & ~i_lsu_valid;
   assign o_empty     = rst & empty;
   assign o_rd_wen    = pop;
   assign o_rd        = empty ? 5'd0 : rd_mem_q[head];
   assign o_rd_data   = empty ? '0   : data_mem_q[head];
   assign o_wb_cnt    = wb_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         wb_cnt_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            rd_mem_q[i]   <= '0;
            data_mem_q[i] <= '0;
         end
      end else begin
         if (push) begin
            rd_mem_q[wr_ptr_q[AW-1:0]]   <= push_rd;
            data_mem_q[wr_ptr_q[AW-1:0]] <= push_data;
            wr_ptr_q                     <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
            wb_cnt_q <= wb_cnt_q + 32'd1;
         end
      end
   end

   // Walk oldest to youngest so the last match is the youngest pending write.
   always_comb begin
      logic [AW-1:0] slot;
      slot      = '0;
      o_rs1_hit = 1'b0;
      o_rs2_hit = 1'b0;
      o_rs1_fwd = '0;
      o_rs2_fwd = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         slot = head + AW'(i);
         if (PW'(i) < cnt) begin
            if ((i_rs1 != 5'd0) && (rd_mem_q[slot] == i_rs1)) begin
               o_rs1_hit = 1'b1;
               o_rs1_fwd = data_mem_q[slot];
            end
            if ((i_rs2 != 5'd0) && (rd_mem_q[slot] == i_rs2)) begin
               o_rs2_hit = 1'b1;
               o_rs2_fwd = data_mem_q[slot];
            end
         end
      end
   end

endmodule

// File: tb/tb_ysyx_210544_wb_commit.sv
// Directed bench for the writeback commit queue; expected values are hand-computed.
module tb_ysyx_210544_wb_commit;

   localparam int unsigned XLEN = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            i_alu_valid, i_lsu_valid, i_wr_stall;
   logic            o_alu_ready, o_lsu_ready;
   logic [4:0]      i_alu_rd, i_lsu_rd, i_rs1, i_rs2, o_rd;
   logic [XLEN-1:0] i_alu_data, i_lsu_data, o_rd_data, o_rs1_fwd, o_rs2_fwd;
   logic            o_rd_wen, o_rs1_hit, o_rs2_hit, o_empty;
   logic [31:0]     o_wb_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ysyx_210544_wb_commit #(.DEPTH(4), .XLEN(XLEN)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_alu_valid (i_alu_valid),
      .o_alu_ready (o_alu_ready),
      .i_alu_rd    (i_alu_rd),
      .i_alu_data  (i_alu_data),
      .i_lsu_valid (i_lsu_valid),
      .o_lsu_ready (o_lsu_ready),
      .i_lsu_rd    (i_lsu_rd),
      .i_lsu_data  (i_lsu_data),
      .i_wr_stall  (i_wr_stall),
      .o_rd        (o_rd),
      .o_rd_wen    (o_rd_wen),
      .o_rd_data   (o_rd_data),
      .i_rs1       (i_rs1),
      .i_rs2       (i_rs2),
      .o_rs1_hit   (o_rs1_hit),
      .o_rs2_hit   (o_rs2_hit),
      .o_rs1_fwd   (o_rs1_fwd),
      .o_rs2_fwd   (o_rs2_fwd),
      .o_wb_cnt    (o_wb_cnt),
      .o_empty     (o_empty)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alu_push(input logic [4:0] rd, input logic [63:0] data);
      i_alu_valid = 1'b1;
      i_alu_rd    = rd;
      i_alu_data  = data;
      #1;
      check_eq("alu_push_ready", o_alu_ready, 1'b1);
      tick();
      i_alu_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      i_alu_valid = 1'b0; i_alu_rd = '0; i_alu_data = '0;
      i_lsu_valid = 1'b0; i_lsu_rd = '0; i_lsu_data = '0;
      i_wr_stall = 1'b0; i_rs1 = '0; i_rs2 = '0;
      #3;
      check_eq("rst_empty", o_empty, 1'b0);
      check_eq("rst_alu_ready", o_alu_ready, 1'b0);
      check_eq("rst_lsu_ready", o_lsu_ready, 1'b0);
      check_eq("rst_wen", o_rd_wen, 1'b0);
      check_eq("rst_wb_cnt", o_wb_cnt, 32'd0);
      tick();
      tick();
      rst = 1'b1;
      #1;
      check_eq("post_rst_empty", o_empty, 1'b1);
      check_eq("post_rst_alu_ready", o_alu_ready, 1'b1);
      check_eq("post_rst_lsu_ready", o_lsu_ready, 1'b1);

      // Single ALU push retires the following cycle.
      alu_push(5'd5, 64'h1234);
      #1;
      check_eq("t1_wen", o_rd_wen, 1'b1);
      check_eq("t1_rd", o_rd, 5'd5);
      check_eq("t1_data", o_rd_data, 64'h1234);
      tick();
      check_eq("t1_wb_cnt", o_wb_cnt, 32'd1);
      check_eq("t1_empty", o_empty, 1'b1);

      // LSU priority over ALU.
      i_lsu_valid = 1'b1; i_lsu_rd = 5'd4; i_lsu_data = 64'h44;
      i_alu_valid = 1'b1; i_alu_rd = 5'd3; i_alu_data = 64'h33;
      #1;
      check_eq("t2_lsu_ready", o_lsu_ready, 1'b1);
      check_eq("t2_alu_blocked", o_alu_ready, 1'b0);
      tick();
      i_lsu_valid = 1'b0;
      #1;
      check_eq("t2_alu_ready", o_alu_ready, 1'b1);
      check_eq("t2_first_rd", o_rd, 5'd4);
      check_eq("t2_first_wen", o_rd_wen, 1'b1);
      tick();
      i_alu_valid = 1'b0;
      #1;
      check_eq("t2_second_rd", o_rd, 5'd3);
      check_eq("t2_second_data", o_rd_data, 64'h33);
      tick();
      check_eq("t2_empty", o_empty, 1'b1);
      check_eq("t2_wb_cnt", o_wb_cnt, 32'd3);

      // Fill under stall, then drain in order.
      i_wr_stall = 1'b1;
      for (int i = 0; i < 4; i++) alu_push(5'(10 + i), 64'h100 + 64'(i));
      i_alu_valid = 1'b1; i_alu_rd = 5'd14; i_alu_data = 64'h999;
      #1;
      check_eq("t3_full_alu_ready", o_alu_ready, 1'b0);
      check_eq("t3_full_lsu_ready", o_lsu_ready, 1'b0);
      check_eq("t3_stall_wen", o_rd_wen, 1'b0);
      i_alu_valid = 1'b0;
      i_wr_stall = 1'b0;
      #1;
      check_eq("t3_full_pop_ready", o_lsu_ready, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check_eq("t3_wen", o_rd_wen, 1'b1);
         check_eq("t3_rd", o_rd, 5'(10 + i));
         check_eq("t3_data", o_rd_data, 64'h100 + 64'(i));
         tick();
         if (i == 0) check_eq("t3_ready_after_pop", o_lsu_ready, 1'b1);
      end
      check_eq("t3_empty", o_empty, 1'b1);
      check_eq("t3_wb_cnt", o_wb_cnt, 32'd7);

      // Forwarding: youngest of two writes to x7 wins.
      i_wr_stall = 1'b1;
      alu_push(5'd7, 64'hA);
      alu_push(5'd7, 64'hB);
      i_rs1 = 5'd7; i_rs2 = 5'd0;
      #1;
      check_eq("t4_rs1_hit", o_rs1_hit, 1'b1);
      check_eq("t4_rs1_fwd", o_rs1_fwd, 64'hB);
      check_eq("t4_rs2_hit", o_rs2_hit, 1'b0);
      check_eq("t4_rs2_fwd", o_rs2_fwd, 64'h0);
      i_wr_stall = 1'b0;
      i_rs2 = 5'd8;
      #1;
      check_eq("t4_miss_hit", o_rs2_hit, 1'b0);
      tick();
      check_eq("t4_retiring_head_hit", o_rs1_hit, 1'b1);
      check_eq("t4_retiring_head_fwd", o_rs1_fwd, 64'hB);
      tick();
      check_eq("t4_drained_hit", o_rs1_hit, 1'b0);
      check_eq("t4_wb_cnt", o_wb_cnt, 32'd9);

      // rd==0 handshake is dropped.
      alu_push(5'd0, 64'hFF);
      #1;
      check_eq("t5_empty", o_empty, 1'b1);
      check_eq("t5_wen", o_rd_wen, 1'b0);
      tick();
      check_eq("t5_wb_cnt", o_wb_cnt, 32'd9);

      // Asynchronous reset mid-stream.
      i_wr_stall = 1'b1;
      for (int i = 0; i < 3; i++) alu_push(5'(20 + i), 64'h200 + 64'(i));
      i_wr_stall = 1'b0;
      i_rs1 = 5'd21;
      #1;
      check_eq("t6_pre_wen", o_rd_wen, 1'b1);
      check_eq("t6_pre_rd", o_rd, 5'd20);
      rst = 1'b0;
      #1;
      check_eq("t6_rst_wen", o_rd_wen, 1'b0);
      check_eq("t6_rst_rd", o_rd, 5'd0);
      check_eq("t6_rst_data", o_rd_data, 64'h0);
      check_eq("t6_rst_ready", o_lsu_ready, 1'b0);
      check_eq("t6_rst_empty", o_empty, 1'b0);
      check_eq("t6_rst_wb_cnt", o_wb_cnt, 32'd0);
      tick();
      rst = 1'b1;
      #1;
      check_eq("t6_post_empty", o_empty, 1'b1);
      check_eq("t6_post_wb_cnt", o_wb_cnt, 32'd0);
      check_eq("t6_post_ready", o_alu_ready, 1'b1);
      check_eq("t6_post_hit", o_rs1_hit, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
